// File: rtl/trace_pkg.sv
// trace_pkg: shared state encodings, capture modes and entry layout for trace_buffer (TRACE_TIMESTAMP_EN adds a timestamp field)
package trace_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
    localparam int MODE_STOP = 0;
    localparam int MODE_WRAP = 1;
    localparam int TRACE_DATA_W = 32;
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W = 32;
`endif
    typedef struct packed {
        logic [TRACE_DATA_W-1:0] pc;
        logic [TRACE_DATA_W-1:0] inst;
        logic [4:0]              waddr;
        logic [TRACE_DATA_W-1:0] wdata;
`ifdef TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]         tstamp;
`endif
    } trace_entry_t;
    // Flat entry width for any data width, keeping the field order of trace_entry_t.
    function automatic int entry_w(input int data_w);
        return $bits(trace_entry_t) + 3 * (data_w - TRACE_DATA_W);
    endfunction
endpackage

// File: rtl/trace_fifo_mem.sv
// trace_fifo_mem: DEPTH x W trace storage with one synchronous write port and one asynchronous read port
module trace_fifo_mem #(
    parameter int W     = 101,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: triggered retire-trace FIFO with stop/wrap modes; define TRACE_TIMESTAMP_EN to store and output a per-entry cycle timestamp
module trace_buffer import trace_pkg::*; #(
    parameter int DATA_W    = TRACE_DATA_W,
    parameter int DEPTH     = 16,
    parameter int MODE      = MODE_STOP,
    parameter int FILTER_WB = 1,
    parameter int POST_CNT  = 0
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   arm,
    input  logic [DATA_W-1:0]      trig_pc,
    input  logic                   cap_valid,
    input  logic [DATA_W-1:0]      cap_pc,
    input  logic [DATA_W-1:0]      cap_inst,
    input  logic                   cap_wena,
    input  logic [4:0]             cap_waddr,
    input  logic [DATA_W-1:0]      cap_wdata,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_pc,
    output logic [DATA_W-1:0]      out_inst,
    output logic [DATA_W-1:0]      out_wdata,
    output logic [4:0]             out_waddr,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]        out_tstamp,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [1:0]             state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_w(DATA_W);
    localparam int PW = $clog2(POST_CNT + 2);
    localparam logic [PW-1:0] POST_LAST = PW'(POST_CNT - 1);
    localparam bit WRAP = MODE == MODE_WRAP;

    state_t st, st_nx;
    logic [AW-1:0] wp, rp;
    logic [PW-1:0] post_cnt;
    logic cap_en, hit, push, pop, last, we;
    logic [EW-1:0] wr_entry, rd_entry;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] tstamp;
    always_ff @(posedge clk_in or posedge reset)
        if (reset) tstamp <= '0;
        else tstamp <= tstamp + TS_W'(1);
    assign wr_entry = {cap_pc, cap_inst, cap_waddr, cap_wdata, tstamp};
    assign {out_pc, out_inst, out_waddr, out_wdata, out_tstamp} = rd_entry;
`else
    assign wr_entry = {cap_pc, cap_inst, cap_waddr, cap_wdata};
    assign {out_pc, out_inst, out_waddr, out_wdata} = rd_entry;
`endif

    always_ff @(posedge clk_in or posedge reset)
        if (reset) st <= IDLE;
        else st <= st_nx;

    assign hit  = cap_valid && cap_pc == trig_pc;
    assign last = POST_CNT != 0 && post_cnt == POST_LAST;

    always_comb
        st_nx = clear ? IDLE :
                arm ? ARMED :
                (push && last) ? DONE :
                (st == ARMED && hit) ? CAPTURE : st;

    always_comb begin
        cap_en = st == CAPTURE || (st == ARMED && hit);
        state  = st;
    end

    // A full buffer still takes the record when a pop frees a slot or when wrapping over the oldest.
    assign push = !clear && cap_valid && (FILTER_WB == 0 || cap_wena) && cap_en;
    assign pop  = !clear && !empty && out_ready;
    assign we   = push && (!full || pop || WRAP);

    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign out_valid = !empty;

    always_ff @(posedge clk_in or posedge reset)
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            post_cnt <= '0;
        end else if (clear) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            post_cnt <= '0;
        end else begin
            if (we) wp <= wp + AW'(1);
            if (pop || (push && full && WRAP)) rp <= rp + AW'(1);
            if (push && !pop && !full) count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (push && full && !pop) overflow <= 1'b1;
            if (arm) post_cnt <= '0;
            else if (push) post_cnt <= post_cnt + PW'(1);
        end

    trace_fifo_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
        .clk   (clk_in),
        .we    (we),
        .waddr (wp),
        .wdata (wr_entry),
        .raddr (rp),
        .rdata (rd_entry)
    );
endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of pc/inst/wdata fields.
REQ-002 SHALL have parameter DEPTH, default 16, entries held; power of two, 2..256.
REQ-003 SHALL have parameter MODE, default 0: 0 = stop-when-full, 1 = circular overwrite.
REQ-004 SHALL have parameter FILTER_WB, default 1: 1 = capture only records with cap_wena=1.
REQ-005 SHALL have parameter POST_CNT, default 0: records captured after trigger; 0 = unlimited.
REQ-006 SHALL have ports, in order:
 clk_in  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-high
 clear  in  1  sync pulse: flush FIFO, clear overflow, go IDLE
 arm  in  1  sync pulse: enter ARMED
 trig_pc  in  DATA_W  trigger PC
 cap_valid  in  1  retire record present
 cap_pc  in  DATA_W  retired PC
 cap_inst  in  DATA_W  retired instruction
 cap_wena  in  1  regfile write enable
 cap_waddr  in  5  regfile write address
 cap_wdata  in  DATA_W  regfile write data
 out_ready  in  1  drain side accepts head
 out_valid  out  1  head entry valid
 out_pc/out_inst/out_wdata  out  DATA_W each  head fields
 out_waddr  out  5  head field
 count  out  $clog2(DEPTH)+1  entries held
 full, empty  out  1 each  count==DEPTH / count==0
 overflow  out  1  sticky: a record was dropped or overwritten
 state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

Function
REQ-007 Entry SHALL be {pc, inst, waddr, wdata}; out_* SHALL show the head combinationally (first-word fall-through); out_valid = !empty.
REQ-008 Push SHALL occur when cap_valid && (FILTER_WB==0 || cap_wena) && (state==CAPTURE || ARMED trigger hit); entry pushed at edge k SHALL be visible on out_* with out_valid=1 from edge k.
REQ-009 Pop SHALL occur when out_valid && out_ready; head advances at the edge.
REQ-010 ARMED->CAPTURE SHALL occur when cap_valid && cap_pc==trig_pc; the trigger record SHALL be pushed that cycle if it passes the filter.
REQ-011 CAPTURE->DONE SHALL occur at the edge the POST_CNT-th post-trigger record (trigger record included) is pushed; POST_CNT=0 never leaves CAPTURE.
REQ-012 arm SHALL move any state to ARMED, reset the post-trigger counter, keep FIFO contents; clear SHALL take priority over arm.
REQ-013 Full, MODE=0, push without pop: record dropped, overflow set, count stays DEPTH.
REQ-014 Full, MODE=1, push without pop: oldest overwritten, head advances, count stays DEPTH, overflow set.
REQ-015 Full with simultaneous push and pop SHALL accept both, count unchanged, overflow unaffected.
REQ-016 Empty with simultaneous push and pop SHALL ignore pop and accept push.
REQ-017 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.
REQ-018 DONE and IDLE SHALL still allow draining.

Reset
REQ-019 reset SHALL asynchronously force state=IDLE, pointers/count=0, overflow=0, post counter=0, out_valid=0, empty=1, full=0; entry storage need not be reset.
REQ-020 reset asserted mid-capture SHALL discard all contents; first post-reset push lands at entry 0.

Configuration
REQ-021 Macro TRACE_TIMESTAMP_EN defined: a 32-bit free-running cycle counter (reset 0, wraps) SHALL be stored per entry and output on out_tstamp (32 bits); undefined: no counter, no out_tstamp port.

Structure
REQ-022 Shared package trace_pkg SHALL hold state encodings, MODE constants and the entry struct typedef.
REQ-023 Storage SHALL be one sub-module trace_fifo_mem (DEPTH x entry width, one write, one async read port); control logic stays in trace_buffer.

Verification
REQ-024 DEPTH=4, MODE=0: arm, trig_pc=0x10, retire 0x0C,0x10,0x14,0x18,0x1C,0x20 all wena=1, out_ready=0 -> count=4, head pc=0x10, overflow=1, 0x20 absent.
REQ-025 DEPTH=4, MODE=1, same stimulus -> count=4, drain order 0x14,0x18,0x1C,0x20, overflow=1.
REQ-026 POST_CNT=3: trigger at 0x40, retire 0x40,0x44,0x48,0x4C -> state=DONE after 0x48, 0x4C not captured, count=3.
REQ-027 FILTER_WB=1: retire 0x10 wena=0 then 0x14 wena=1 waddr=5 wdata=0xDEADBEEF in CAPTURE -> one entry, out_waddr=5, out_wdata=0xDEADBEEF.
REQ-028 Full FIFO with push+pop same cycle, then reset pulse mid-stream -> count stays 4, overflow=0; after reset empty=1, state=0, out_valid=0.
